// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port arbiter slice.
//   ADDR_W_DEF / DATA_W_DEF : default SRAM word-address and data widths
//   RD_LAT_DEF              : controller read latency, issue cycle to valid ctl_rdata
//   lock_state_e            : bus-lock FSM encoding (UNLOCKED, LOCKED0, LOCKED1)
package sram_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  localparam int RD_LAT_DEF = 3;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/sram_rd_tracker.sv
// Read-return tracker: a DEPTH-deep shift register of {valid, port} entries.
// One entry enters every cycle (valid only for a read issue) and the entry at
// the tail marks which port owns the word currently on ctl_rdata.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (clears valid bits)
//   push             : a read issues this cycle
//   port             : issuing port of that read (0 or 1)
//   rvalid0/rvalid1  : tail entry is a valid read belonging to port 0 / port 1
module sram_rd_tracker
  import sram_pkg::*;
#(
  parameter int DEPTH = RD_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic port,
  output logic rvalid0,
  output logic rvalid1
);

  logic [DEPTH-1:0] vld_sr;
  logic [DEPTH-1:0] port_sr;

  // Valid bits are control: cleared at once so reads outstanding at reset
  // never produce a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  // Port tags are only meaningful alongside a set valid bit, so no reset.
  always_ff @(posedge clk) begin
    port_sr[0] <= port;
    for (int i = 1; i < DEPTH; i++) begin
      port_sr[i] <= port_sr[i-1];
    end
  end

  assign rvalid0 = vld_sr[DEPTH-1] & ~port_sr[DEPTH-1];
  assign rvalid1 = vld_sr[DEPTH-1] &  port_sr[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of the single-chip SRAM controller.
// Commands issue only when ctl_ready=1; selection is round-robin
// (PRIO_MODE=0) or port-0 fixed priority (PRIO_MODE=1), with an optional
// per-port bus lock. Read returns are steered back to the issuing port.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   req/rw/lock/addr/wdata 0,1  : client command inputs (rw: 1=read, 0=write)
//   gnt0/gnt1                   : combinational accept pulse
//   rvalid0/rvalid1, rdata0/1   : per-port read return (rdata is 0 when not valid)
//   ctl_mem/rw/addr/wdata       : command to controller
//   ctl_ready, ctl_rdata        : controller accept and registered read data
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int PRIO_MODE = 0,
  parameter int RD_LAT    = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ctl_mem,
  output logic              ctl_rw,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic              ctl_ready,
  input  logic [DATA_W-1:0] ctl_rdata
);

  lock_state_e state;
  lock_state_e state_nxt;
  logic        last;   // 1: port 1 was granted most recently
  logic        elig0;
  logic        elig1;

  // A lock owned by one port masks the other port's request entirely.
  assign elig0 = req0 && (state != LOCKED1);
  assign elig1 = req1 && (state != LOCKED0);

  // State register: lock FSM and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= UNLOCKED;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (gnt0 || gnt1) begin
        last <= gnt1;
      end
    end
  end

  // Next-state logic: the owner releases by dropping req or by taking a
  // grant with its lock bit clear.
  always_comb begin
    state_nxt = state;
    unique case (state)
      UNLOCKED: begin
        if (gnt0 && lock0) begin
          state_nxt = LOCKED0;
        end else if (gnt1 && lock1) begin
          state_nxt = LOCKED1;
        end
      end
      LOCKED0: begin
        if (!req0 || (gnt0 && !lock0)) begin
          state_nxt = UNLOCKED;
        end
      end
      LOCKED1: begin
        if (!req1 || (gnt1 && !lock1)) begin
          state_nxt = UNLOCKED;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  // Output logic: grants. Reset gates them so nothing leaks out while the
  // arbiter is held in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (ctl_ready && !reset) begin
      if (elig0 && elig1) begin
        if (PRIO_MODE == 1 || last) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  // Command mux defaults to port 0 when idle.
  assign ctl_mem   = gnt0 | gnt1;
  assign ctl_rw    = gnt1 ? rw1    : rw0;
  assign ctl_addr  = gnt1 ? addr1  : addr0;
  assign ctl_wdata = gnt1 ? wdata1 : wdata0;

  sram_rd_tracker #(
    .DEPTH (RD_LAT)
  ) u_rd_tracker (
    .clk     (clk),
    .reset   (reset),
    .push    (ctl_mem && ctl_rw),
    .port    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1)
  );

  assign rdata0 = rvalid0 ? ctl_rdata : '0;
  assign rdata1 = rvalid1 ? ctl_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus; a per-cycle reference model (lock owner,
// last-granted port, and a return-slot table keyed by due cycle) predicts
// every output, and directed sequences check grant/return ordering.
module tb_sram_port_arbiter;
  import sram_pkg::*;

  localparam int AW  = ADDR_W_DEF;
  localparam int DW  = DATA_W_DEF;
  localparam int LAT = RD_LAT_DEF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
  logic          lock0 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ctl_ready = 1'b0;
  logic [DW-1:0] ctl_rdata = '0;

  logic [1:0]    gnt0, gnt1, rvalid0, rvalid1, ctl_mem, ctl_rw;
  logic [DW-1:0] rdata0 [2];
  logic [DW-1:0] rdata1 [2];
  logic [AW-1:0] ctl_addr [2];
  logic [DW-1:0] ctl_wdata [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    sram_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(m), .RD_LAT(LAT)
    ) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0[m]), .gnt1(gnt1[m]),
      .rvalid0(rvalid0[m]), .rvalid1(rvalid1[m]),
      .rdata0(rdata0[m]), .rdata1(rdata1[m]),
      .ctl_mem(ctl_mem[m]), .ctl_rw(ctl_rw[m]),
      .ctl_addr(ctl_addr[m]), .ctl_wdata(ctl_wdata[m]),
      .ctl_ready(ctl_ready), .ctl_rdata(ctl_rdata)
    );
  end

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int owner [2];     // -1 none, else locking port
  int last_p [2];    // last granted port
  int slot [2][8];   // due-cycle table: 0 none, p+1 = read of port p due
  int last_g0 = -1;  // model grant of instance 0 in the previous cycle

  int g0_p[$], g0_c[$], g1_p[$];
  int rv_p[$], rv_c[$], rv_d[$];

  logic [3:0] lock_tbl [9] = '{  // {ready, req0, req1, lock1}
    4'b1011, 4'b0111, 4'b1111, 4'b0111, 4'b1111,
    4'b0110, 4'b1110, 4'b0100, 4'b1100
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(int m);
    bit e0, e1;
    if (reset || !ctl_ready) return -1;
    e0 = req0 && owner[m] != 1;
    e1 = req1 && owner[m] != 0;
    if (e0 && e1) return (m == 1 || last_p[m] == 1) ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic void model_reset(int m);
    owner[m] = -1;
    last_p[m] = 1;
    for (int k = 0; k < 8; k++) slot[m][k] = 0;
  endfunction

  task automatic cycle();
    int g, rp;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      g  = pick(m);
      rp = reset ? 0 : slot[m][cyc % 8];
      chk($sformatf("gnt%0d", m), {gnt1[m], gnt0[m]}, {g == 1, g == 0});
      chk($sformatf("ctl_mem%0d", m), 32'(ctl_mem[m]), 32'(g >= 0));
      chk($sformatf("rvalid%0d", m), {rvalid1[m], rvalid0[m]}, {rp == 2, rp == 1});
      chk($sformatf("rdata0_%0d", m), 32'(rdata0[m]), (rp == 1) ? 32'(ctl_rdata) : 32'd0);
      chk($sformatf("rdata1_%0d", m), 32'(rdata1[m]), (rp == 2) ? 32'(ctl_rdata) : 32'd0);
      if (g >= 0) begin
        chk($sformatf("ctl_rw%0d", m), 32'(ctl_rw[m]), 32'(g == 0 ? rw0 : rw1));
        chk($sformatf("ctl_addr%0d", m), 32'(ctl_addr[m]), 32'(g == 0 ? addr0 : addr1));
        chk($sformatf("ctl_wdata%0d", m), 32'(ctl_wdata[m]), 32'(g == 0 ? wdata0 : wdata1));
      end
      // observed logs for the directed ordering checks
      if (gnt0[m] || gnt1[m]) begin
        if (m == 0) begin
          g0_p.push_back(gnt1[m] ? 1 : 0);
          g0_c.push_back(cyc);
        end else begin
          g1_p.push_back(gnt1[m] ? 1 : 0);
        end
      end
      if (m == 0 && (rvalid0[0] || rvalid1[0])) begin
        rv_p.push_back(rvalid1[0] ? 1 : 0);
        rv_c.push_back(cyc);
        rv_d.push_back(int'(rvalid1[0] ? rdata1[0] : rdata0[0]));
      end
      // advance the model to the state after the coming edge
      slot[m][cyc % 8] = 0;
      if (reset) begin
        model_reset(m);
      end else begin
        if (g >= 0 && (g == 0 ? rw0 : rw1)) slot[m][(cyc + LAT) % 8] = g + 1;
        if (owner[m] >= 0) begin
          if (!(owner[m] == 0 ? req0 : req1)) owner[m] = -1;
          else if (g == owner[m] && !(g == 0 ? lock0 : lock1)) owner[m] = -1;
        end else if (g >= 0 && (g == 0 ? lock0 : lock1)) begin
          owner[m] = g;
        end
        if (g >= 0) last_p[m] = g;
      end
      if (m == 0) last_g0 = g;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    g0_p.delete(); g0_c.delete(); g1_p.delete();
    rv_p.delete(); rv_c.delete(); rv_d.delete();
  endtask

  task automatic reset_pulse();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; ctl_ready = 0;
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    int t0;
    model_reset(0);
    model_reset(1);

    // Reset with a live request and ready: every output must stay 0.
    req0 = 1; rw0 = 1; ctl_ready = 1; reset = 1;
    cycle(); cycle();
    reset = 0; req0 = 0; ctl_ready = 0;
    cycle();

    // Single read from port 0.
    clear_logs();
    ctl_rdata = 16'hA5A5;
    req0 = 1; rw0 = 1; addr0 = 18'h00010; ctl_ready = 1;
    t0 = cyc;
    cycle();
    req0 = 0; ctl_ready = 0; cycle();
    ctl_ready = 1; cycle(); cycle(); cycle();
    chk("single_gnt_count", g0_p.size(), 1);
    if (g0_c.size() == 1) chk("single_gnt_cycle", g0_c[0], t0);
    chk("single_rv_count", rv_p.size(), 1);
    if (rv_p.size() == 1) begin
      chk("single_rv_port", rv_p[0], 0);
      chk("single_rv_cycle", rv_c[0], t0 + 3);
      chk("single_rv_data", rv_d[0], 32'hA5A5);
    end

    // Round-robin tie over four reads at 2-cycle controller spacing.
    reset_pulse();
    clear_logs();
    req0 = 1; req1 = 1; rw0 = 1; rw1 = 1; addr0 = 18'h00100; addr1 = 18'h00200;
    for (int i = 0; i < 8; i++) begin
      ctl_ready = (i % 2 == 0);
      ctl_rdata = DW'($urandom);
      cycle();
    end
    req0 = 0; req1 = 0; ctl_ready = 1;
    for (int i = 0; i < 4; i++) begin
      ctl_rdata = DW'($urandom);
      cycle();
    end
    chk("rr_gnt_count", g0_p.size(), 4);
    chk("rr_rv_count", rv_p.size(), 4);
    if (g0_p.size() == 4 && rv_p.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr_gnt_port%0d", i), g0_p[i], i % 2);
        chk($sformatf("rr_gnt_gap%0d", i), g0_c[i] - g0_c[0], 2 * i);
        chk($sformatf("rr_rv_port%0d", i), rv_p[i], i % 2);
        chk($sformatf("rr_rv_lat%0d", i), rv_c[i] - g0_c[i], 3);
      end
    end

    // Fixed priority (instance 1): port 0 keeps winning until it drops req.
    reset_pulse();
    clear_logs();
    req0 = 1; req1 = 1; rw0 = 1; rw1 = 1;
    for (int i = 0; i < 6; i++) begin
      ctl_ready = (i % 2 == 0);
      cycle();
    end
    req0 = 0; ctl_ready = 1; cycle();
    req1 = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("prio_gnt_count", g1_p.size(), 4);
    if (g1_p.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("prio_gnt_port%0d", i), g1_p[i], (i == 3) ? 1 : 0);
    end

    // Bus lock held by port 1 for writes while port 0 waits.
    reset_pulse();
    clear_logs();
    rw0 = 0; rw1 = 0; wdata0 = 16'h1111; wdata1 = 16'h2222;
    for (int i = 0; i < 9; i++) begin
      ctl_ready = lock_tbl[i][3];
      req0      = lock_tbl[i][2];
      req1      = lock_tbl[i][1];
      lock1     = lock_tbl[i][0];
      cycle();
    end
    req0 = 0; req1 = 0; lock1 = 0; cycle();
    chk("lock_gnt_count", g0_p.size(), 5);
    chk("lock_gnt_count_prio", g1_p.size(), 5);
    if (g0_p.size() == 5 && g1_p.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("lock_gnt_port%0d", i), g0_p[i], (i == 4) ? 0 : 1);
        chk($sformatf("lock_gnt_port_prio%0d", i), g1_p[i], (i == 4) ? 0 : 1);
      end
    end

    // Ready gating: no grant while the controller is busy.
    clear_logs();
    req0 = 1; rw0 = 0; ctl_ready = 0;
    t0 = cyc;
    for (int i = 0; i < 5; i++) cycle();
    ctl_ready = 1; cycle();
    req0 = 0; cycle();
    chk("ready_gnt_count", g0_p.size(), 1);
    if (g0_c.size() == 1) chk("ready_gnt_cycle", g0_c[0], t0 + 5);

    // Reset one cycle after a read issue drops that read's return.
    clear_logs();
    req0 = 1; rw0 = 1; ctl_ready = 1; cycle();
    req0 = 0; ctl_ready = 0; reset = 1; cycle();
    reset = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("rst_rv_dropped", rv_p.size(), 0);
    req0 = 1; ctl_ready = 1; ctl_rdata = 16'h5A5A;
    t0 = cyc;
    cycle();
    req0 = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_after_rv_count", rv_p.size(), 1);
    if (rv_c.size() == 1) chk("rst_after_rv_cycle", rv_c[0], t0 + 3);

    // Randomized traffic, controller ready at most every other cycle.
    for (int i = 0; i < 600; i++) begin
      req0   = ($urandom % 4) != 0;
      req1   = ($urandom % 4) != 0;
      rw0    = $urandom % 2;
      rw1    = $urandom % 2;
      lock0  = ($urandom % 3) == 0;
      lock1  = ($urandom % 3) == 0;
      addr0  = AW'($urandom);
      addr1  = AW'($urandom);
      wdata0 = DW'($urandom);
      wdata1 = DW'($urandom);
      ctl_rdata = DW'($urandom);
      ctl_ready = (last_g0 < 0) && (($urandom % 5) != 0);
      reset  = ($urandom % 150) == 0;
      cycle();
    end
    reset = 0; req0 = 0; req1 = 0;
    for (int i = 0; i < 5; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
